bus_multiplier: RTL and testbench
=================================

Name: bus_multiplier

Overview:
- Iterative shift-add unsigned multiplier attached to the shared OR-combined data bus alongside the general-purpose registers.
- Consumes operands driven onto the bus by register `out` ports.
- Returns the 2*width product in two bus-width halves, each gated by its own output enable, for write-back into registers.
- Multi-cycle, one bit per clock, with a start/busy/done handshake owned by the control sequencer.

Parameters:
- width, 32, operand width and bus width in bits; product is 2*width bits.

Ports:
- clk  input  1  system clock; all state changes on rising edge
- rst  input  1  asynchronous, active-low reset
- in  input  width  shared data bus, operand source
- we_a  input  1  load operand A (multiplicand) from `in` at clock edge
- we_b  input  1  load operand B (multiplier) from `in` at clock edge
- start  input  1  begin multiplication of current A and B
- oe_lo  input  1  drive product bits [width-1:0] onto `out`
- oe_hi  input  1  drive product bits [2*width-1:width] onto `out`
- out  output  width  bus contribution; 0 when not enabled
- busy  output  1  high while multiplying
- done  output  1  high while a completed product is held

Behaviour:
- Reset (rst low, asynchronous):
  - Clears A, B, product, step counter.
  - state=IDLE, busy=0, done=0, out=0.
  - Takes effect immediately, including mid-operation; the partial result is discarded.
- State encoding: IDLE, RUN, DONE.
- Operand registers:
  - we_a/we_b load `in` on the rising edge when state is IDLE or DONE.
  - Ignored in RUN.
  - A value loaded in DONE does not alter the held product.
- IDLE or DONE with start=1 at an edge:
  - Working multiplicand := A.
  - Working register {hi, lo} := {0, B}.
  - counter := 0; state := RUN; busy := 1; done := 0.
  - start samples operand values present before that edge. A simultaneous we_a/we_b updates the operand register only and affects the next operation, not this one.
- RUN, each edge (one step):
  - If lo[0]=1: hi := hi + multiplicand, computed at width+1 bits with carry kept.
  - {carry, hi, lo} shifts right one bit.
  - counter increments.
  - On the step where counter == width-1: state := DONE, busy := 0, done := 1.
- Latency:
  - Exactly width steps.
  - done first reads 1 after width+1 rising edges, counting the edge that sampled start.
  - For width=32: 33 edges.
- start in RUN is ignored; no restart, no queueing.
- DONE:
  - Product held stable indefinitely.
  - done stays 1 until the next accepted start or reset.
- Output gating (combinational):
  - out = (oe_lo & ~busy ? lo : 0) | (oe_hi & ~busy ? hi : 0).
  - Both enables high ORs the halves, per bus convention. The sequencer must not do this in normal operation.
  - While busy, out is forced to 0 so partial products never reach the bus.
  - In IDLE after reset, out returns the zero product.
- Arithmetic:
  - Unsigned only.
  - Product never overflows 2*width bits.
  - Zero operands and all-ones operands need no special handling.

Test Plan:
- width=8; load A=13 (we_a), B=11 (we_b), pulse start.
  -> busy=1 for 8 cycles; done=1 on edge 9.
  -> oe_lo gives 0x8F; oe_hi gives 0x00.
- width=8; A=0xFF, B=0xFF, start.
  -> oe_lo gives 0x01, oe_hi gives 0xFE.
  -> Assert out=0 on every cycle where busy=1, even with oe_lo=oe_hi=1.
- width=8; A=0, B=0xA5, start.
  -> Product 0; completes in the same 9 edges.
  -> Then re-start with A=3, B=0: product 0, done drops on the start edge and re-rises 9 edges later.
- width=8; A=7, B=6, start.
  -> Pulse start and we_a with in=0x55 at step 3: both ignored, product 42.
  -> Then in DONE, we_a with in=2: product stays 42; the next start with B=6 gives 12.
- width=8; start with A=9, B=9.
  -> Drive rst low asynchronously mid-edge at step 4: busy, done and out go 0 immediately.
  -> After release, state is IDLE and the oe_lo read is 0.
- width=8; in DONE with product 0xFE01, assert oe_lo and oe_hi together.
  -> out=0xFF (OR of halves).
  -> Simultaneous we_a=1 with in=0x10 and start=1: this run uses the old A; the following run uses 0x10.

Source files
------------

// File: rtl/bus_multiplier.sv
// Iterative shift-add unsigned multiplier on the shared OR-combined data bus.
// One product bit per clock; the product is read back as two gated bus-width halves.
module bus_multiplier #(
  parameter int width = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [width-1:0] in,
  input  logic             we_a,
  input  logic             we_b,
  input  logic             start,
  input  logic             oe_lo,
  input  logic             oe_hi,
  output logic [width-1:0] out,
  output logic             busy,
  output logic             done
);

  // state | meaning
  // IDLE  | no product computed since reset; operands may be loaded
  // RUN   | shifting/adding one multiplier bit per clock
  // DONE  | product held; operands may be loaded, start begins a new run
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam int CW = (width > 1) ? $clog2(width) : 1;

  state_t              state_q, state_d;
  logic [width-1:0]    a_q, a_d;
  logic [width-1:0]    b_q, b_d;
  logic [width-1:0]    mcand_q, mcand_d;
  logic [width-1:0]    hi_q, hi_d;
  logic [width-1:0]    lo_q, lo_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [width:0]      sum;
  logic                accept;
  logic                last_step;

  assign accept    = (state_q != RUN) && start;
  assign last_step = (cnt_q == CW'(width - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last_step) state_d = DONE;
      DONE:    if (start) state_d = RUN;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == RUN);
    done = (state_q == DONE);
    out  = ((oe_lo && !busy) ? lo_q : '0) | ((oe_hi && !busy) ? hi_q : '0);
  end

  // Carry out of the add lands in hi[width-1] after the right shift.
  always_comb begin
    sum     = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mcand_q} : {(width+1){1'b0}});
    a_d     = a_q;
    b_d     = b_q;
    mcand_d = mcand_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    cnt_d   = cnt_q;
    if (state_q != RUN) begin
      if (we_a) a_d = in;
      if (we_b) b_d = in;
    end
    if (accept) begin
      mcand_d = a_q;
      hi_d    = '0;
      lo_d    = b_q;
      cnt_d   = '0;
    end else if (state_q == RUN) begin
      hi_d  = sum[width:1];
      lo_d  = {sum[0], lo_q[width-1:1]};
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_q     <= '0;
      b_q     <= '0;
      mcand_q <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      cnt_q   <= '0;
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      mcand_q <= mcand_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_bus_multiplier.sv
// Directed bench for bus_multiplier (width=8): bus reads go through a scoreboard queue,
// handshake timing and reset behaviour are checked inline.
module tb_bus_multiplier;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] bus_in = '0;
  logic       we_a = 1'b0, we_b = 1'b0, start = 1'b0, oe_lo = 1'b0, oe_hi = 1'b0;
  logic [7:0] bus_out;
  logic       busy, done;

  int total = 0;
  int bad = 0;
  logic       rd_req = 1'b0;
  logic [7:0] exp_q[$];
  string      name_q[$];

  bus_multiplier #(.width(8)) dut (
    .clk(clk), .rst(rst_n), .in(bus_in), .we_a(we_a), .we_b(we_b), .start(start),
    .oe_lo(oe_lo), .oe_hi(oe_hi), .out(bus_out), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Scoreboard monitor: a bus read is presented while rd_req is high.
  always @(negedge clk) begin
    if (rd_req) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL sb_underflow: read with no expected value, got %h", bus_out);
      end else begin
        automatic logic [7:0] e = exp_q.pop_front();
        automatic string n = name_q.pop_front();
        if (bus_out !== e) begin
          bad++;
          $display("FAIL %s: got %h expected %h", n, bus_out, e);
        end
      end
    end
  end

  // Partial products must never reach the bus.
  always @(negedge clk) begin
    if (rst_n && busy === 1'b1) begin
      total++;
      if (bus_out !== 8'h00) begin
        bad++;
        $display("FAIL out_while_busy: got %h expected 00", bus_out);
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic rd(input logic lo, input logic hi, input logic [7:0] exp, input string name);
    oe_lo = lo;
    oe_hi = hi;
    rd_req = 1'b1;
    exp_q.push_back(exp);
    name_q.push_back(name);
    tick;
    rd_req = 1'b0;
    oe_lo = 1'b0;
    oe_hi = 1'b0;
  endtask

  task automatic load(input logic [7:0] a, input logic [7:0] b);
    bus_in = a; we_a = 1'b1;
    tick;
    we_a = 1'b0; bus_in = b; we_b = 1'b1;
    tick;
    we_b = 1'b0; bus_in = '0;
  endtask

  // Start a run and check the 8-step busy window and done on the 9th edge.
  task automatic go(input bit oe_both, input int inj_step, input bit sim_a, input logic [7:0] sim_a_val);
    start = 1'b1;
    if (sim_a) begin we_a = 1'b1; bus_in = sim_a_val; end
    oe_lo = oe_both; oe_hi = oe_both;
    tick;
    start = 1'b0; we_a = 1'b0; bus_in = '0;
    chk("busy_after_start", {15'd0, busy}, 16'd1);
    chk("done_drops_on_start", {15'd0, done}, 16'd0);
    for (int i = 1; i < 8; i++) begin
      if (i == inj_step) begin start = 1'b1; we_a = 1'b1; bus_in = 8'h55; end
      tick;
      start = 1'b0; we_a = 1'b0; bus_in = '0;
      chk("busy_during_run", {15'd0, busy}, 16'd1);
      chk("done_during_run", {15'd0, done}, 16'd0);
    end
    tick;
    chk("busy_at_edge9", {15'd0, busy}, 16'd0);
    chk("done_at_edge9", {15'd0, done}, 16'd1);
    oe_lo = 1'b0; oe_hi = 1'b0;
  endtask

  initial begin
    repeat (2) tick;
    oe_lo = 1'b1; oe_hi = 1'b1;
    #1;
    chk("reset_busy", {15'd0, busy}, 16'd0);
    chk("reset_done", {15'd0, done}, 16'd0);
    chk("reset_out", {8'd0, bus_out}, 16'd0);
    oe_lo = 1'b0; oe_hi = 1'b0;
    rst_n = 1'b1;
    tick;
    rd(1, 0, 8'h00, "idle_zero_product");

    // 13 * 11 = 143
    load(8'd13, 8'd11);
    go(0, 0, 0, 8'h00);
    rd(1, 0, 8'h8F, "p13x11_lo");
    rd(0, 1, 8'h00, "p13x11_hi");

    // 255 * 255 = 0xFE01, enables held high while busy
    load(8'hFF, 8'hFF);
    go(1, 0, 0, 8'h00);
    rd(1, 0, 8'h01, "pffxff_lo");
    rd(0, 1, 8'hFE, "pffxff_hi");
    rd(1, 1, 8'hFF, "pffxff_or_halves");

    // start with simultaneous we_a: this run keeps old A, next run uses 0x10
    go(0, 0, 1, 8'h10);
    rd(1, 0, 8'h01, "old_a_lo");
    rd(0, 1, 8'hFE, "old_a_hi");
    go(0, 0, 0, 8'h00);
    rd(1, 0, 8'hF0, "new_a_lo");
    rd(0, 1, 8'h0F, "new_a_hi");

    // zero multiplicand, then zero multiplier
    load(8'h00, 8'hA5);
    go(0, 0, 0, 8'h00);
    rd(1, 0, 8'h00, "p0xa5_lo");
    rd(0, 1, 8'h00, "p0xa5_hi");
    load(8'd3, 8'd0);
    go(0, 0, 0, 8'h00);
    rd(1, 0, 8'h00, "p3x0_lo");

    // start/we_a during RUN ignored; we_a in DONE leaves product intact
    load(8'd7, 8'd6);
    go(0, 3, 0, 8'h00);
    rd(1, 0, 8'h2A, "p7x6_lo");
    rd(0, 1, 8'h00, "p7x6_hi");
    bus_in = 8'd2; we_a = 1'b1;
    tick;
    we_a = 1'b0; bus_in = '0;
    rd(1, 0, 8'h2A, "held_after_we_a");
    go(0, 0, 0, 8'h00);
    rd(1, 0, 8'h0C, "p2x6_lo");

    // async reset mid-run
    load(8'd9, 8'd9);
    start = 1'b1;
    tick;
    start = 1'b0;
    repeat (3) tick;
    oe_lo = 1'b1; oe_hi = 1'b1;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_busy", {15'd0, busy}, 16'd0);
    chk("rst_mid_done", {15'd0, done}, 16'd0);
    chk("rst_mid_out", {8'd0, bus_out}, 16'd0);
    oe_lo = 1'b0; oe_hi = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick;
    chk("post_rst_busy", {15'd0, busy}, 16'd0);
    chk("post_rst_done", {15'd0, done}, 16'd0);
    rd(1, 0, 8'h00, "post_rst_lo");

    repeat (2) tick;
    chk("sb_drained", exp_q.size(), 16'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
